// File: rtl/core_lsu_ctrl.sv
// core_lsu_ctrl -- RV32 load/store unit controller.
// Accepts one memory request at a time from the pipeline, drives a simple
// req/ack word bus with byte-lane enables, and returns an extended load
// result plus a fault code through a one-cycle done pulse.
//
// Ports:
//   i_clk, i_reset          clock, async active-high reset
//   i_valid/o_ready         request handshake (accepted when both high)
//   i_store, i_funct3       access type (RV32 load/store funct3)
//   i_addr, i_rs2_val       byte address, store source data
//   o_done, o_rdata,o_fault completion pulse, load result, fault code
//                           (00 ok, 01 misaligned/illegal, 10 bus err, 11 timeout)
//   o_bus_*                 bus request, write enable, word address,
//                           lane-replicated write data, byte-lane enables
//   i_bus_ack/err/rdata     bus response
module core_lsu_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_valid,
  input  logic        i_store,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_rs2_val,
  output logic        o_ready,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic [1:0]  o_fault,
  output logic        o_bus_req,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [31:0] o_bus_wdata,
  output logic [3:0]  o_bus_sel,
  input  logic        i_bus_ack,
  input  logic        i_bus_err,
  input  logic [31:0] i_bus_rdata
);

  localparam logic [7:0] TMO = TIMEOUT_CYCLES[7:0];

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  // Latched request fields needed after acceptance; the word part of the
  // address lives in o_bus_addr.
  typedef struct packed {
    logic       store;
    logic [2:0] funct3;
    logic [1:0] lane;
  } req_t;

  state_t      state;
  req_t        req;
  logic [7:0]  cnt;

  logic        bad_req;
  logic [3:0]  sel_next;
  logic [31:0] wdata_next;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_data;

  assign o_ready = (state == IDLE);

  // Request decode on the incoming (not yet latched) fields.
  always_comb begin
    bad_req    = 1'b0;
    sel_next   = 4'b1111;
    wdata_next = i_rs2_val;
    case (i_funct3[1:0])
      2'b00: begin
        sel_next   = 4'b0001 << i_addr[1:0];
        wdata_next = {4{i_rs2_val[7:0]}};
      end
      2'b01: begin
        sel_next   = i_addr[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{i_rs2_val[15:0]}};
        bad_req    = i_addr[0];
      end
      2'b10:   bad_req = (i_addr[1:0] != 2'b00);
      default: bad_req = 1'b1;
    endcase
    // Unsigned stores do not exist.
    if (i_store && i_funct3[2]) bad_req = 1'b1;
  end

  // Load lane extraction from the latched address; funct3[2] selects
  // zero extension (LBU/LHU).
  always_comb begin
    case (req.lane)
      2'd0:    byte_lane = i_bus_rdata[7:0];
      2'd1:    byte_lane = i_bus_rdata[15:8];
      2'd2:    byte_lane = i_bus_rdata[23:16];
      default: byte_lane = i_bus_rdata[31:24];
    endcase
    half_lane = req.lane[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];
    case (req.funct3[1:0])
      2'b00:   load_data = {{24{~req.funct3[2] & byte_lane[7]}}, byte_lane};
      2'b01:   load_data = {{16{~req.funct3[2] & half_lane[15]}}, half_lane};
      default: load_data = i_bus_rdata;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state       <= IDLE;
      req         <= '0;
      cnt         <= '0;
      o_done      <= 1'b0;
      o_rdata     <= '0;
      o_fault     <= 2'b00;
      o_bus_req   <= 1'b0;
      o_bus_we    <= 1'b0;
      o_bus_addr  <= '0;
      o_bus_wdata <= '0;
      o_bus_sel   <= '0;
    end else begin
      case (state)
        IDLE: begin
          o_done <= 1'b0;
          if (i_valid) begin
            req         <= '{store: i_store, funct3: i_funct3, lane: i_addr[1:0]};
            o_bus_addr  <= {i_addr[31:2], 2'b00};
            o_bus_we    <= i_store;
            o_bus_wdata <= wdata_next;
            o_bus_sel   <= sel_next;
            if (bad_req) begin
              // Illegal requests never touch the bus.
              state   <= DONE;
              o_done  <= 1'b1;
              o_fault <= 2'b01;
              o_rdata <= '0;
            end else begin
              state     <= BUS;
              o_bus_req <= 1'b1;
              cnt       <= 8'd1;
            end
          end
        end
        BUS: begin
          // Priority: err > ack > timeout.
          if (i_bus_err || i_bus_ack || cnt == TMO) begin
            state     <= DONE;
            o_done    <= 1'b1;
            o_bus_req <= 1'b0;
            cnt       <= '0;
            o_rdata   <= '0;
            if (i_bus_err)      o_fault <= 2'b10;
            else if (i_bus_ack) begin
              o_fault <= 2'b00;
              if (!req.store) o_rdata <= load_data;
            end
            else                o_fault <= 2'b11;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: begin
          o_done <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_lsu_ctrl.sv
// Directed bench for core_lsu_ctrl with a transaction-level model.
// Each transaction's outcome (fault, load value, lanes, completion cycle)
// is computed arithmetically from the access rules; a single compare
// process checks the DUT against those expectations every cycle, and
// literal values pin the key scenarios.
module tb_core_lsu_ctrl;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid = 0, i_store = 0;
  logic [2:0]  i_funct3 = 0;
  logic [31:0] i_addr = 0, i_rs2_val = 0;
  logic        o_ready, o_done, o_bus_req, o_bus_we;
  logic [31:0] o_rdata, o_bus_addr, o_bus_wdata;
  logic [1:0]  o_fault;
  logic [3:0]  o_bus_sel;
  logic        i_bus_ack = 0, i_bus_err = 0;
  logic [31:0] i_bus_rdata = 0;

  core_lsu_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(clk), .i_reset(rst), .i_valid(i_valid), .i_store(i_store),
    .i_funct3(i_funct3), .i_addr(i_addr), .i_rs2_val(i_rs2_val),
    .o_ready(o_ready), .o_done(o_done), .o_rdata(o_rdata), .o_fault(o_fault),
    .o_bus_req(o_bus_req), .o_bus_we(o_bus_we), .o_bus_addr(o_bus_addr),
    .o_bus_wdata(o_bus_wdata), .o_bus_sel(o_bus_sel),
    .i_bus_ack(i_bus_ack), .i_bus_err(i_bus_err), .i_bus_rdata(i_bus_rdata)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h @%0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle expectations, driven by run_txn
  logic        chk_en = 0;
  logic        exp_ready, exp_req, exp_done, exp_we;
  logic [31:0] exp_rdata, exp_addr, exp_wd;
  logic [1:0]  exp_fault;
  logic [3:0]  exp_sel;

  always @(negedge clk) if (chk_en) begin
    chk("ready", 32'(o_ready), 32'(exp_ready));
    chk("bus_req", 32'(o_bus_req), 32'(exp_req));
    chk("done", 32'(o_done), 32'(exp_done));
    if (exp_done) begin
      chk("rdata", o_rdata, exp_rdata);
      chk("fault", 32'(o_fault), 32'(exp_fault));
    end
    if (exp_req) begin
      chk("bus_addr", o_bus_addr, exp_addr);
      chk("bus_we", 32'(o_bus_we), 32'(exp_we));
      chk("bus_sel", 32'(o_bus_sel), 32'(exp_sel));
      chk("bus_wdata", o_bus_wdata, exp_wd);
    end
  end

  // Observed values for literal pinning
  int          cap_done, req_cnt;
  logic [31:0] cap_rdata, cap_wd, cap_addr;
  logic [1:0]  cap_fault;
  logic [3:0]  cap_sel;
  logic        cap_we;

  // kind: 0 no response, 1 ack, 2 err, 3 ack+err; resp_at = req cycle index
  task automatic run_txn(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] rs2, input logic [31:0] brd,
                         input int resp_at, input int kind);
    int sz, lo, term;
    logic ill;
    logic [31:0] raw, ld;
    sz = int'(f3) & 3;
    lo = int'(a % 4);
    ill = (sz == 3) || (sz == 1 && lo % 2 != 0) || (sz == 2 && lo != 0) || (st && f3 >= 4);
    exp_sel = (sz == 0) ? 4'(1 << lo) : (sz == 1) ? ((lo >= 2) ? 4'hC : 4'h3) : 4'hF;
    exp_wd  = (sz == 0) ? {24'b0, rs2[7:0]} * 32'h0101_0101 :
              (sz == 1) ? {16'b0, rs2[15:0]} * 32'h0001_0001 : rs2;
    raw = brd >> (8 * lo);
    if (sz == 0) begin
      ld = raw & 32'hFF;
      if (f3 < 4 && raw[7]) ld = ld | 32'hFFFF_FF00;
    end else if (sz == 1) begin
      ld = raw & 32'hFFFF;
      if (f3 < 4 && raw[15]) ld = ld | 32'hFFFF_0000;
    end else ld = brd;
    if (ill) term = 0;
    else if (kind != 0 && resp_at >= 1 && resp_at <= TMO) term = resp_at;
    else term = TMO;
    if (ill) exp_fault = 2'b01;
    else if (kind != 0 && term == resp_at) exp_fault = (kind >= 2) ? 2'b10 : 2'b00;
    else exp_fault = 2'b11;
    exp_rdata = (exp_fault == 2'b00 && !st) ? ld : 32'h0;
    exp_addr  = {a[31:2], 2'b00};
    exp_we    = st;
    cap_done = -1; req_cnt = 0;
    cap_rdata = 'x; cap_fault = 'x; cap_sel = 'x; cap_wd = 'x; cap_addr = 'x; cap_we = 'x;
    for (int c = 0; c <= term + 2; c++) begin
      @(posedge clk); #1;
      i_valid = (c <= term + 1);
      if (c == 0) begin
        i_store = st; i_funct3 = f3; i_addr = a; i_rs2_val = rs2;
      end else begin
        // junk request while busy must be ignored
        i_store = ~st; i_funct3 = 3'b010; i_addr = 32'hFFFF_FFF0; i_rs2_val = ~rs2;
      end
      i_bus_rdata = brd;
      i_bus_ack = (!ill && c == resp_at && (kind == 1 || kind == 3)) || (c == term + 1) || (c == term + 2);
      i_bus_err = (!ill && c == resp_at && kind >= 2);
      exp_ready = (c == 0) || (c == term + 2);
      exp_req   = !ill && c >= 1 && c <= term;
      exp_done  = (c == term + 1);
      chk_en = 1;
      @(negedge clk);
      if (o_done && cap_done < 0) begin
        cap_done = c; cap_rdata = o_rdata; cap_fault = o_fault;
      end
      if (o_bus_req) begin
        req_cnt++; cap_sel = o_bus_sel; cap_wd = o_bus_wdata; cap_addr = o_bus_addr; cap_we = o_bus_we;
      end
    end
  endtask

  initial begin
    // reset state
    @(negedge clk);
    chk("rst ready", 32'(o_ready), 32'd1);
    chk("rst done", 32'(o_done), 32'd0);
    chk("rst req", 32'(o_bus_req), 32'd0);
    chk("rst outs", o_bus_addr | o_bus_wdata | o_rdata | 32'(o_bus_sel) | 32'(o_fault) | 32'(o_bus_we), 32'd0);
    @(posedge clk); #1 rst = 0;

    // LB 0x103, ack on 3rd req cycle
    run_txn(0, 3'b000, 32'h103, 32'h0, 32'h80FF_FF00, 3, 1);
    chk("lb sel", 32'(cap_sel), 32'h8);
    chk("lb addr", cap_addr, 32'h100);
    chk("lb rdata", cap_rdata, 32'hFFFF_FF80);
    chk("lb fault", 32'(cap_fault), 32'h0);
    chk("lb done cyc", cap_done, 4);

    // SH 0x22, immediate ack
    run_txn(1, 3'b001, 32'h22, 32'h1234_ABCD, 32'h0, 1, 1);
    chk("sh we", 32'(cap_we), 32'h1);
    chk("sh sel", 32'(cap_sel), 32'hC);
    chk("sh wdata", cap_wd, 32'hABCD_ABCD);
    chk("sh done cyc", cap_done, 2);

    // LW misaligned
    run_txn(0, 3'b010, 32'h6, 32'h0, 32'h0, 1, 1);
    chk("lw mis req", req_cnt, 0);
    chk("lw mis done cyc", cap_done, 1);
    chk("lw mis fault", 32'(cap_fault), 32'h1);

    // LHU timeout
    run_txn(0, 3'b101, 32'h0, 32'h0, 32'hFFFF_FFFF, 0, 0);
    chk("tmo req cycles", req_cnt, 4);
    chk("tmo done cyc", cap_done, 5);
    chk("tmo fault", 32'(cap_fault), 32'h3);

    // ack and err together
    run_txn(0, 3'b010, 32'h10, 32'h0, 32'h5555_AAAA, 2, 3);
    chk("ackerr fault", 32'(cap_fault), 32'h2);
    chk("ackerr rdata", cap_rdata, 32'h0);

    // LH upper half, ack on the timeout cycle wins
    run_txn(0, 3'b001, 32'h2, 32'h0, 32'h8001_1234, TMO, 1);
    chk("lh rdata", cap_rdata, 32'hFFFF_8001);
    chk("lh fault", 32'(cap_fault), 32'h0);

    run_txn(0, 3'b100, 32'h101, 32'h0, 32'h1122_33F4, 1, 1);   // LBU lane 1
    chk("lbu rdata", cap_rdata, 32'h33);
    run_txn(1, 3'b000, 32'h3, 32'h0000_00A5, 32'h0, 2, 1);     // SB lane 3
    chk("sb wdata", cap_wd, 32'hA5A5_A5A5);
    run_txn(1, 3'b010, 32'h8, 32'hDEAD_BEEF, 32'h0, 2, 2);     // SW bus error
    run_txn(1, 3'b100, 32'h0, 32'h0, 32'h0, 1, 1);             // store funct3[2]=1
    run_txn(0, 3'b011, 32'h0, 32'h0, 32'h0, 1, 1);             // size 11
    run_txn(1, 3'b001, 32'h1, 32'h0, 32'h0, 1, 1);             // SH odd

    // Reset in the middle of a bus transfer
    @(posedge clk); #1;
    chk_en = 0; i_bus_ack = 0; i_bus_err = 0;
    i_valid = 1; i_store = 0; i_funct3 = 3'b010; i_addr = 32'h40;
    @(posedge clk); #1 i_valid = 0;
    @(posedge clk);
    @(negedge clk);
    chk("pre-rst req", 32'(o_bus_req), 32'd1);
    #1 rst = 1;
    #1;
    chk("mid-rst req", 32'(o_bus_req), 32'd0);
    chk("mid-rst ready", 32'(o_ready), 32'd1);
    chk("mid-rst done", 32'(o_done), 32'd0);
    @(posedge clk); #1 rst = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post-rst done", 32'(o_done), 32'd0);
      chk("post-rst ready", 32'(o_ready), 32'd1);
    end
    run_txn(0, 3'b010, 32'h44, 32'h0, 32'hCAFE_F00D, 1, 1);
    chk("lw after rst", cap_rdata, 32'hCAFE_F00D);

    @(posedge clk); #1 chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/core_lsu_ctrl.md
CORE_LSU_CTRL -- requirements
Module: core_lsu_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning max bus wait cycles before a timeout fault (range 1..255).
REQ-002 SHALL have port i_clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-003 SHALL have port i_reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port i_valid, input, 1 bit: pipeline memory request.
REQ-005 SHALL have port i_store, input, 1 bit: 1 = store, 0 = load.
REQ-006 SHALL have port i_funct3, input, 3 bits: RV32 load/store funct3.
REQ-007 SHALL have port i_addr, input, 32 bits: effective byte address.
REQ-008 SHALL have port i_rs2_val, input, 32 bits: store source data.
REQ-009 SHALL have port o_ready, output, 1 bit: request accepted when i_valid & o_ready.
REQ-010 SHALL have port o_done, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port o_rdata, output, 32 bits: extended load result, valid with o_done.
REQ-012 SHALL have port o_fault, output, 2 bits: 00 ok, 01 misaligned/illegal size, 10 bus error, 11 timeout; valid with o_done.
REQ-013 SHALL have port o_bus_req, output, 1 bit: bus request.
REQ-014 SHALL have port o_bus_we, output, 1 bit: bus write enable.
REQ-015 SHALL have port o_bus_addr, output, 32 bits: word address, bits [1:0] = 0.
REQ-016 SHALL have port o_bus_wdata, output, 32 bits: lane-replicated store data.
REQ-017 SHALL have port o_bus_sel, output, 4 bits: byte-lane enables.
REQ-018 SHALL have port i_bus_ack, input, 1 bit: transfer complete.
REQ-019 SHALL have port i_bus_err, input, 1 bit: transfer error.
REQ-020 SHALL have port i_bus_rdata, input, 32 bits: read data, valid with i_bus_ack.

Function
REQ-021 SHALL implement states IDLE, BUS and DONE; o_ready = 1 only in IDLE; i_valid is ignored outside IDLE.
REQ-022 SHALL, on acceptance, latch i_store, i_funct3 and i_addr, and compute o_bus_addr = {addr[31:2],2'b00}, o_bus_we = i_store.
REQ-023 SHALL set o_bus_wdata to {4{rs2[7:0]}} for size 00, {2{rs2[15:0]}} for size 01, and rs2 otherwise (size = funct3[1:0]).
REQ-024 SHALL set o_bus_sel to one-hot lane addr[1:0] for byte, 0011/1100 by addr[1] for half, and 1111 for word.
REQ-025 SHALL treat an accepted request as faulting with cause 01 when size = 11, half with addr[0] = 1, word with addr[1:0] != 0, or store with funct3[2] = 1; such a request SHALL go IDLE -> DONE, with o_bus_req never asserted.
REQ-026 SHALL, for a legal request, go IDLE -> BUS and register o_bus_req = 1 in the cycle after acceptance.
REQ-027 SHALL hold o_bus_req and all bus outputs stable in BUS until i_bus_err, i_bus_ack or timeout.
REQ-028 SHALL give priority err > ack > timeout when these occur in the same cycle.
REQ-029 SHALL, on i_bus_err in BUS, drop o_bus_req next cycle, go to DONE with fault 10, and set o_rdata = 0.
REQ-030 SHALL, on i_bus_ack in BUS, drop o_bus_req next cycle and go to DONE with fault 00.
REQ-031 SHALL, for a load ack, extract the lane selected by latched addr into o_rdata, sign-extended when funct3[2] = 0 and zero-extended otherwise; store ack SHALL give o_rdata = 0.
REQ-032 SHALL count 8-bit wait cycles in BUS starting at 1 on the first req cycle; when count = TIMEOUT_CYCLES without ack/err, it SHALL drop req, go to DONE with fault 11, and clear the counter on leaving BUS.
REQ-033 SHALL assert o_done for exactly one cycle in DONE, then return to IDLE, making o_ready = 1 in the following cycle.
REQ-034 SHALL have zero-wait latency: accept at cycle 0, req cycles 1..N, ack at N, o_done at N+1.
REQ-035 SHALL ignore i_bus_ack and i_bus_err outside BUS.

Reset
REQ-036 SHALL, while i_reset = 1 and immediately (asynchronously), set state IDLE, o_bus_req = 0, o_bus_we = 0, o_bus_addr = 0, o_bus_wdata = 0, o_bus_sel = 0, o_done = 0, o_rdata = 0, o_fault = 00 and counter = 0, giving o_ready = 1.
REQ-037 SHALL abandon any in-flight transfer on reset mid-BUS without generating o_done.

Verification
REQ-038 SHALL be verified by: LB addr 0x103, bus rdata 0x80FF_FF00, ack after 2 cycles -> sel 1000, bus_addr 0x100, o_rdata 0xFFFFFF80, fault 00, o_done at cycle 4.
REQ-039 SHALL be verified by: SH addr 0x22, rs2 0x1234ABCD, immediate ack -> we = 1, sel 1100, wdata 0xABCDABCD, o_done at cycle 2.
REQ-040 SHALL be verified by: LW addr 0x6 -> no bus_req, o_done next cycle, fault 01.
REQ-041 SHALL be verified by: LHU addr 0x0 with TIMEOUT_CYCLES = 4 and no ack -> req high for cycles 1..4, o_done at cycle 5, fault 11.
REQ-042 SHALL be verified by: ack and err together -> fault 10, o_rdata 0.
REQ-043 SHALL be verified by: reset pulse mid-BUS -> o_bus_req low during reset, no o_done, o_ready = 1, then a new LW succeeds.
